// File: rtl/ram_dp_clr.sv
// Single-clock dual-port RAM with a read/write CPU port (A), a read-only scan port (B),
// selectable read-during-write behaviour, optional output register and a full-memory clear engine.
module ram_dp_clr #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      ADDR_BITS   = 14,
  parameter int unsigned      READ_MODE   = 0,
  parameter int unsigned      OUT_REG     = 0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_en,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [WIDTH-1:0]     a_wdata,
  output logic [WIDTH-1:0]     a_rdata,
  output logic                 a_rvalid,
  input  logic                 b_en,
  input  logic [ADDR_BITS-1:0] b_addr,
  output logic [WIDTH-1:0]     b_rdata,
  output logic                 b_rvalid,
  input  logic                 clear_start,
  output logic                 busy
);

  localparam int unsigned          DEPTH       = 2**ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR   = '1;
  localparam bit                   WRITE_FIRST = (READ_MODE != 0);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] cnt;
  logic                 busy_q;

  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 a_acc;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic [WIDTH-1:0]     a_word;
  logic [WIDTH-1:0]     b_word;

  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 a_v;
  logic                 b_v;

  // The single write port is owned by the clear engine while busy; port A is locked out then.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    a_acc   = a_en && !busy_q;
    wr_en   = 1'b0;
    wr_addr = a_addr;
    wr_data = a_wdata;
    if (busy_q) begin
      wr_en   = 1'b1;
      wr_addr = cnt;
      wr_data = CLEAR_VALUE;
    end else if (a_acc && a_we) begin
      wr_en = 1'b1;
    end
  end

  // Write-first forwards the word being written this cycle to any port reading the same address.
  always_comb begin
    a_word = mem[a_addr];
    b_word = mem[b_addr];
    if (WRITE_FIRST && wr_en && (wr_addr == a_addr)) begin
      a_word = wr_data;
    end
    if (WRITE_FIRST && wr_en && (wr_addr == b_addr)) begin
      b_word = wr_data;
    end
  end

  // Clear engine: one word per cycle, stops after the last address without wrapping.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_BITS'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset; contents survive reset and map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // First read stage: data only reloads on an accepted request, otherwise it holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      a_v <= 1'b0;
      b_q <= '0;
      b_v <= 1'b0;
    end else begin
      a_v <= a_acc;
      b_v <= b_en;
      if (a_acc) begin
        a_q <= a_word;
      end
      if (b_en) begin
        b_q <= b_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] a_q2;
    logic [WIDTH-1:0] b_q2;
    logic             a_v2;
    logic             b_v2;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_q2 <= '0;
        a_v2 <= 1'b0;
        b_q2 <= '0;
        b_v2 <= 1'b0;
      end else begin
        a_v2 <= a_v;
        b_v2 <= b_v;
        if (a_v) begin
          a_q2 <= a_q;
        end
        if (b_v) begin
          b_q2 <= b_q;
        end
      end
    end

    assign a_rdata  = a_q2;
    assign a_rvalid = a_v2;
    assign b_rdata  = b_q2;
    assign b_rvalid = b_v2;
  end else begin : g_no_out_reg
    assign a_rdata  = a_q;
    assign a_rvalid = a_v;
    assign b_rdata  = b_q;
    assign b_rvalid = b_v;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr: four instances (read-first/write-first x OUT_REG 0/1) share
// one stimulus stream; a behavioural memory model queues expected read results per instance and port.
module tb_ram_dp_clr;

  localparam int          AB    = 4;
  localparam int          DEPTH = 16;
  localparam int          N     = 4;
  localparam logic [15:0] CV    = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_en = 1'b0;
  logic        a_we = 1'b0;
  logic [3:0]  a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        b_en = 1'b0;
  logic [3:0]  b_addr = '0;
  logic        clear_start = 1'b0;

  logic [15:0] a_rdata [N];
  logic [15:0] b_rdata [N];
  logic        a_rvalid [N];
  logic        b_rvalid [N];
  logic        busy [N];

  typedef struct packed {
    logic [15:0] data;
    logic [31:0] due;
  } exp_t;

  exp_t        qa [N][$];
  exp_t        qb [N][$];
  logic [15:0] last_a [N];
  logic [15:0] last_b [N];

  logic [15:0] model [DEPTH];
  logic        m_busy = 1'b0;
  logic [3:0]  m_cnt = '0;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Instance i: READ_MODE = i % 2, OUT_REG = i / 2.
  for (genvar g = 0; g < N; g++) begin : g_dut
    ram_dp_clr #(
      .WIDTH      (16),
      .ADDR_BITS  (AB),
      .READ_MODE  (g % 2),
      .OUT_REG    (g / 2),
      .CLEAR_VALUE(CV)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .a_en       (a_en),
      .a_we       (a_we),
      .a_addr     (a_addr),
      .a_wdata    (a_wdata),
      .a_rdata    (a_rdata[g]),
      .a_rvalid   (a_rvalid[g]),
      .b_en       (b_en),
      .b_addr     (b_addr),
      .b_rdata    (b_rdata[g]),
      .b_rvalid   (b_rvalid[g]),
      .clear_start(clear_start),
      .busy       (busy[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of stimulus. Called at posedge+1; the model is advanced to the post-edge state.
  task automatic step(input logic ae, input logic we, input logic [3:0] aa, input logic [15:0] wd,
                      input logic be, input logic [3:0] ba, input logic cs);
    logic        acc;
    logic        wen;
    logic [3:0]  wa;
    logic [15:0] wdat;
    logic [15:0] d;
    a_en = ae; a_we = we; a_addr = aa; a_wdata = wd;
    b_en = be; b_addr = ba; clear_start = cs;
    acc  = ae && !m_busy;
    wen  = 1'b0;
    wa   = aa;
    wdat = wd;
    if (m_busy) begin
      wen = 1'b1; wa = m_cnt; wdat = CV;
    end else if (acc && we) begin
      wen = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      int mode;
      int oreg;
      mode = i % 2;
      oreg = i / 2;
      if (acc) begin
        d = (mode == 1 && we) ? wd : model[aa];
        qa[i].push_back('{data: d, due: 32'(cyc + 1 + oreg)});
      end
      if (be) begin
        d = (mode == 1 && wen && wa == ba) ? wdat : model[ba];
        qb[i].push_back('{data: d, due: 32'(cyc + 1 + oreg)});
      end
    end
    if (wen) model[wa] = wdat;
    if (m_busy) begin
      if (m_cnt == 4'hF) m_busy = 1'b0;
      else m_cnt = m_cnt + 4'd1;
    end else if (cs) begin
      m_busy = 1'b1;
      m_cnt  = '0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_busy));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    step(1'b1, 1'b1, a, d, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) wr(4'(i), 16'(i + 1));
  endtask

  // Asserts reset mid-cycle, checks the asynchronous zeroing, then releases after a clock.
  task automatic do_reset();
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; clear_start = 1'b0;
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_a_rvalid[%0d]", i), 32'(a_rvalid[i]), 32'd0);
      check($sformatf("rst_b_rvalid[%0d]", i), 32'(b_rvalid[i]), 32'd0);
      check($sformatf("rst_a_rdata[%0d]", i), 32'(a_rdata[i]), 32'd0);
      check($sformatf("rst_b_rdata[%0d]", i), 32'(b_rdata[i]), 32'd0);
      check($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
      qa[i].delete();
      qb[i].delete();
      last_a[i] = '0;
      last_b[i] = '0;
    end
    m_busy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard: rvalid must match the queue head's due cycle; otherwise rdata must hold.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        logic ev;
        ev = (qa[i].size() > 0) && (qa[i][0].due == cyc);
        check($sformatf("a_rvalid[%0d]", i), 32'(a_rvalid[i]), 32'(ev));
        if (ev) begin
          check($sformatf("a_rdata[%0d]", i), 32'(a_rdata[i]), 32'(qa[i][0].data));
          last_a[i] = qa[i][0].data;
          void'(qa[i].pop_front());
        end else begin
          check($sformatf("a_hold[%0d]", i), 32'(a_rdata[i]), 32'(last_a[i]));
        end
        ev = (qb[i].size() > 0) && (qb[i][0].due == cyc);
        check($sformatf("b_rvalid[%0d]", i), 32'(b_rvalid[i]), 32'(ev));
        if (ev) begin
          check($sformatf("b_rdata[%0d]", i), 32'(b_rdata[i]), 32'(qb[i][0].data));
          last_b[i] = qb[i][0].data;
          void'(qb[i].pop_front());
        end else begin
          check($sformatf("b_hold[%0d]", i), 32'(b_rdata[i]), 32'(last_b[i]));
        end
      end
    end
  end

  initial begin
    int nb;
    for (int i = 0; i < N; i++) begin
      last_a[i] = '0;
      last_b[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0;
    #2;
    do_reset();

    // Initial clear gives every word a known value; busy must last exactly 16 cycles.
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b1);
    nb = 0;
    for (int k = 0; k < 24; k++) begin
      if (busy[0]) nb++;
      idle();
    end
    check("clear0_busy_cycles", 32'(nb), 32'd16);

    // Basic write/read on both ports.
    preload();
    wr(4'd3, 16'hBEEF);
    step(1'b1, 1'b0, 4'd3, 16'd0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 1'b0);
    idle();

    // Same-address collision: A writes 0x2222 while B reads address 5 holding 0x1111.
    wr(4'd5, 16'h1111);
    step(1'b1, 1'b1, 4'd5, 16'h2222, 1'b1, 4'd5, 1'b0);
    idle();
    step(1'b1, 1'b0, 4'd5, 16'd0, 1'b1, 4'd5, 1'b0);
    idle();

    // Streaming: B reads 0..7 while A reads 8..15 back to back.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i + 8), 16'd0, 1'b1, 4'(i), 1'b0);
    idle(); idle(); idle();

    // Full clear: coincident write accepted then overwritten, dropped write and ignored
    // restart during busy, B reads colliding with the word being cleared on even cycles.
    preload();
    step(1'b1, 1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 1'b1);
    nb = 0;
    for (int k = 0; k < 24; k++) begin
      logic [3:0] ba;
      if (busy[0]) nb++;
      ba = k[0] ? 4'(k + 3) : 4'(k);
      if (k == 2) step(1'b1, 1'b1, 4'd2, 16'hDEAD, 1'b1, ba, 1'b0);
      else        step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, ba, (k == 4));
    end
    check("clear1_busy_cycles", 32'(nb), 32'd16);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 4'(i), 16'd0, 1'b0, 4'd0, 1'b0);
    idle(); idle();

    // Reset after six clear writes leaves 0..5 cleared, the rest intact; a new clear restarts at 0.
    preload();
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'(k), 1'b0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'(i), 1'b0);
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b1);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy[0]) nb++;
      step(1'b0, 1'b0, 4'd0, 16'd0, (k == 0), 4'd0, 1'b0);
    end
    check("clear2_busy_cycles", 32'(nb), 32'd16);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 4'(i), 16'd0, 1'b1, 4'(15 - i), 1'b0);
    idle(); idle(); idle();

    for (int i = 0; i < N; i++) begin
      check($sformatf("drain_a[%0d]", i), 32'(qa[i].size()), 32'd0);
      check($sformatf("drain_b[%0d]", i), 32'(qb[i].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_dp_clr.md
# ram_dp_clr

Parametrised single-clock dual-port RAM that generalises the team's fixed 16K×16 memory. It has configurable width and depth, a selectable read-during-write mode, an optional output pipeline register, and per-port read-valid strobes. A built-in clear engine sweeps every word to a constant value. Port A is the CPU read/write port; port B is a read-only scan port, for example the screen or debug reader.

## Interface
Parameters:
- WIDTH, 16, data word width in bits
- ADDR_BITS, 14, address width; depth = 2**ADDR_BITS
- READ_MODE, 0, 0 = read-first (old data on same-address write), 1 = write-first (new data)
- OUT_REG, 0, 1 adds one output pipeline stage on both ports
- CLEAR_VALUE, 0, word written to every address by the clear engine

Ports (all signals share one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous active-high reset
- a_en  in  1  port A access request
- a_we  in  1  port A write enable (valid with a_en)
- a_addr  in  ADDR_BITS  port A address
- a_wdata  in  WIDTH  port A write data
- a_rdata  out  WIDTH  port A read data
- a_rvalid  out  1  a_rdata valid strobe
- b_en  in  1  port B read request
- b_addr  in  ADDR_BITS  port B address
- b_rdata  out  WIDTH  port B read data
- b_rvalid  out  1  b_rdata valid strobe
- clear_start  in  1  one-cycle request to start a memory clear
- busy  out  1  clear engine active

## Operation
- Reset values:
  - a_rdata, b_rdata = 0; a_rvalid, b_rvalid = 0; busy = 0.
  - The FSM goes to IDLE.
  - Memory contents are not affected by reset.
- Port A, with a_en=1 while not busy:
  - Reads mem[a_addr]. It also writes a_wdata if a_we=1.
  - Every accepted access produces an a_rvalid pulse, including writes.
  - On a write, a_rdata follows READ_MODE: the old word in read-first mode, a_wdata in write-first mode.
- Port B, with b_en=1:
  - Reads mem[b_addr].
  - Port B is always served, including while busy.
- Collision (same cycle, a_we=1, b_addr==a_addr, port A accepted):
  - b_rdata follows READ_MODE exactly as a_rdata does.
- Clear FSM has two states:
  - IDLE: clear_start=1 moves to CLEAR; the address counter loads 0 and busy goes to 1 on the next edge.
  - CLEAR: writes CLEAR_VALUE to mem[cnt] each cycle, then cnt increments. When cnt == 2**ADDR_BITS-1 is written, the FSM returns to IDLE and busy drops on that edge.
  - A clear therefore takes exactly 2**ADDR_BITS cycles with busy=1.
- Port A behaviour relative to the clear:
  - While busy, port A requests are dropped: no write, no a_rvalid. The caller must hold off while busy.
  - If clear_start and a port A write occur in the same cycle, the write is accepted, because busy is still 0. The clear then overwrites it.
  - clear_start while busy is ignored; a clear is not restarted.
- Port B during a clear:
  - A port B read of the address being cleared in the same cycle follows READ_MODE.
  - Other addresses return their current contents, cleared or not yet cleared.
- Reset mid-clear:
  - The FSM returns to IDLE and busy goes to 0 immediately (asynchronously).
  - Memory is left partially cleared: words below cnt equal CLEAR_VALUE, the rest keep their old data.
- The counter is ADDR_BITS wide and must not wrap into a second pass.

## Timing
- Read latency is 1 + OUT_REG cycles from the request edge to data.
- rvalid is asserted in the same cycle the data is presented.
- rvalid is a single-cycle pulse per request.
- Back-to-back requests give one result per cycle; throughput is 1 access per port per cycle.
- With OUT_REG=1, rdata holds its last value between pulses, and the pipeline stage is also cleared by reset.
- rdata holds its value when no new request arrives (no return to 0).
- busy is registered: high from the edge after clear_start, low on the edge after the last clear write.

## Test plan
- Reset, then idle: after reset deasserts, all outputs are 0 and busy=0. Asserting reset asynchronously mid-cycle zeroes rvalid and rdata before the next edge.
- Basic read/write (WIDTH=16, ADDR_BITS=4, OUT_REG=0):
  - Write 0xBEEF to address 3, then read address 3 on port A: a_rdata=0xBEEF with a_rvalid one cycle later.
  - Read address 3 on port B: b_rdata=0xBEEF after 1 cycle.
- Collision, READ_MODE=0 then 1 (mem[5]=0x1111):
  - Same cycle, port A writes 0x2222 to address 5 and port B reads address 5.
  - Required: b_rdata=0x1111 and a_rdata=0x1111 in mode 0; 0x2222 for both in mode 1.
- OUT_REG=1 streaming: port B reads addresses 0..7 on consecutive cycles. b_rvalid is high for 8 consecutive cycles starting 2 cycles after the first request, with data in order.
- Full clear (ADDR_BITS=4, CLEAR_VALUE=0xA5A5), memory preloaded with address+1:
  - Pulse clear_start: busy=1 for exactly 16 cycles.
  - A port A write during busy is dropped, with no a_rvalid.
  - Afterwards all 16 words read 0xA5A5.
- Reset mid-clear: assert reset after 6 clear cycles. busy=0 at once, addresses 0..5 read 0xA5A5, addresses 6..15 keep preload values, and a new clear_start restarts from address 0.
